// File: rtl/condicionador_botao_pkg.sv
// Shared definitions for the pedestrian button conditioner: FSM state codes,
// default filter/lockout lengths and the press-counter ceiling.
package condicionador_botao_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FILTRA = 2'b01,
      PRESS  = 2'b10,
      BLOQ   = 2'b11
   } estado_t;

   localparam logic [7:0] DEBOUNCE_DEF = 8'd3;
   localparam logic [7:0] BLOQUEIO_DEF = 8'd4;
   localparam logic [7:0] CONTAGEM_MAX = 8'd255;

endpackage

// File: rtl/condicionador_botao_sincronizador.sv
// Two-flop synchronizer bringing the asynchronous button line into the clk domain.
module sincronizador (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic ff_p0;
   logic ff_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff_p0 <= 1'b0;
         ff_p1 <= 1'b0;
      end else begin
         ff_p0 <= d;
         ff_p1 <= ff_p0;
      end
   end

   assign q = ff_p1;

endmodule

// File: rtl/condicionador_botao.sv
// Pedestrian button conditioner: synchronize, debounce, emit one bt pulse per
// accepted press, then lock out re-triggers for BLOQUEIO cycles after release.
module condicionador_botao
   import condicionador_botao_pkg::*;
#(
   parameter logic [7:0] DEBOUNCE = DEBOUNCE_DEF,
   parameter logic [7:0] BLOQUEIO = BLOQUEIO_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bt_raw,
   output logic       bt,
   output logic [7:0] contagem,
   output logic [1:0] estado
);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == CONTAGEM_MAX) ? v : v + 8'd1;
   endfunction

   logic       bt_s;
   estado_t    state;
   logic [7:0] cnt;

   sincronizador u_sinc (
      .clk (clk),
      .rst (rst),
      .d   (bt_raw),
      .q   (bt_s)
   );

   // bt is asserted only on the transition into PRESS, so holding the button
   // keeps the FSM in PRESS without generating further pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         bt       <= 1'b0;
         contagem <= 8'd0;
      end else begin
         bt <= 1'b0;
         case (state)
            IDLE: begin
               if (bt_s) begin
                  if (DEBOUNCE == 8'd1) begin
                     state    <= PRESS;
                     cnt      <= 8'd0;
                     bt       <= 1'b1;
                     contagem <= sat_inc(contagem);
                  end else begin
                     state <= FILTRA;
                     cnt   <= 8'd1;
                  end
               end
            end
            FILTRA: begin
               if (!bt_s) begin
                  state <= IDLE;
                  cnt   <= 8'd0;
               end else if (cnt + 8'd1 == DEBOUNCE) begin
                  state    <= PRESS;
                  cnt      <= 8'd0;
                  bt       <= 1'b1;
                  contagem <= sat_inc(contagem);
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            PRESS: begin
               if (!bt_s) begin
                  state <= (BLOQUEIO == 8'd0) ? IDLE : BLOQ;
                  cnt   <= 8'd0;
               end
            end
            BLOQ: begin
               if (cnt + 8'd1 == BLOQUEIO) begin
                  state <= IDLE;
                  cnt   <= 8'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 8'd0;
            end
         endcase
      end
   end

   assign estado = state;

endmodule

// File: tb/tb_condicionador_botao.sv
// Scoreboard bench for condicionador_botao: stimulus queues expected pulses,
// a negedge monitor matches every bt pulse against the queue.
module tb_condicionador_botao;

   typedef struct {
      int         cyc;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       bt_raw;
   logic       bt;
   logic [7:0] contagem;
   logic [1:0] estado;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] model_cnt = 8'd0;

   condicionador_botao #(
      .DEBOUNCE (8'd3),
      .BLOQUEIO (8'd4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bt_raw   (bt_raw),
      .bt       (bt),
      .contagem (contagem),
      .estado   (estado)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && bt === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected at cyc=%0d contagem=%0d required=no pulse", cyc, contagem);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc || mon_e.cnt !== contagem) begin
               errors++;
               $display("FAIL pulse cyc=%0d contagem=%0d required cyc=%0d contagem=%0d",
                        cyc, contagem, mon_e.cyc, mon_e.cnt);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Called at a negedge right after bt_raw rises: pulse seen DEBOUNCE+2 edges later.
   task automatic expect_pulse();
      model_cnt = (model_cnt == 8'd255) ? model_cnt : model_cnt + 8'd1;
      sb.push_back('{cyc + 5, model_cnt});
   endtask

   initial begin
      rst    = 1'b1;
      bt_raw = 1'b1;
      #1;
      chk("reset_bt", {31'd0, bt}, 32'd0);
      chk("reset_contagem", {24'd0, contagem}, 32'd0);
      chk("reset_estado", {30'd0, estado}, 32'd0);
      repeat (2) @(negedge clk);
      chk("reset_held_bt", {31'd0, bt}, 32'd0);
      chk("reset_held_estado", {30'd0, estado}, 32'd0);
      rst    = 1'b0;
      bt_raw = 1'b0;
      repeat (3) @(negedge clk);

      // glitch: two cycles high, never reaches DEBOUNCE
      bt_raw = 1'b1;
      repeat (2) @(negedge clk);
      bt_raw = 1'b0;
      @(negedge clk);
      chk("glitch_filtra", {30'd0, estado}, 32'd1);
      repeat (5) @(negedge clk);
      chk("glitch_idle", {30'd0, estado}, 32'd0);
      chk("glitch_contagem", {24'd0, contagem}, 32'd0);

      // clean press held 10 cycles
      bt_raw = 1'b1;
      expect_pulse();
      repeat (7) @(negedge clk);
      chk("press_estado", {30'd0, estado}, 32'd2);
      chk("press_contagem", {24'd0, contagem}, 32'd1);
      chk("press_bt_done", {31'd0, bt}, 32'd0);
      repeat (3) @(negedge clk);
      bt_raw = 1'b0;

      // re-press inside lockout window
      repeat (2) @(negedge clk);
      bt_raw = 1'b1;
      repeat (2) @(negedge clk);
      bt_raw = 1'b0;
      chk("lockout_estado", {30'd0, estado}, 32'd3);
      repeat (10) @(negedge clk);
      chk("lockout_idle", {30'd0, estado}, 32'd0);
      chk("lockout_contagem", {24'd0, contagem}, 32'd1);

      // press after lockout
      bt_raw = 1'b1;
      expect_pulse();
      repeat (6) @(negedge clk);
      bt_raw = 1'b0;
      repeat (10) @(negedge clk);
      chk("second_contagem", {24'd0, contagem}, 32'd2);
      chk("second_estado", {30'd0, estado}, 32'd0);
      chk("second_sb_empty", sb.size(), 32'd0);

      // reset during the bt pulse
      bt_raw = 1'b1;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      chk("midrst_pulse_up", {31'd0, bt}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_bt", {31'd0, bt}, 32'd0);
      chk("midrst_estado", {30'd0, estado}, 32'd0);
      chk("midrst_contagem", {24'd0, contagem}, 32'd0);
      model_cnt = 8'd0;
      @(negedge clk);
      bt_raw = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("postrst_estado", {30'd0, estado}, 32'd0);
      chk("postrst_bt", {31'd0, bt}, 32'd0);

      // saturation
      for (int i = 0; i < 260; i++) begin
         bt_raw = 1'b1;
         expect_pulse();
         repeat (6) @(negedge clk);
         bt_raw = 1'b0;
         repeat (10) @(negedge clk);
      end
      chk("sat_contagem", {24'd0, contagem}, 32'd255);
      chk("sat_sb_empty", sb.size(), 32'd0);
      bt_raw = 1'b1;
      expect_pulse();
      repeat (6) @(negedge clk);
      bt_raw = 1'b0;
      repeat (10) @(negedge clk);
      chk("sat_hold", {24'd0, contagem}, 32'd255);
      chk("final_sb_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/condicionador_botao.md
CONDICIONADOR_BOTAO -- requirements
Module: condicionador_botao

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 8'd3, consecutive synchronized-high cycles needed to accept a press (legal 1..255).
REQ-002 SHALL have parameter BLOQUEIO, default 8'd4, lockout cycles after release during which input is ignored (legal 0..255).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port bt_raw, input, 1, raw pedestrian button, asynchronous to clk, may bounce.
REQ-006 SHALL have port bt, output, 1, one-cycle registered press pulse; drives the traffic-light controller's bt input.
REQ-007 SHALL have port contagem, output, 8, accepted-press counter.
REQ-008 SHALL have port estado, output, 2, current FSM state (debug).

Function
REQ-009 SHALL pass bt_raw through a 2-flop synchronizer producing bt_s; bt_s SHALL be the only input the FSM sees.
REQ-010 SHALL implement FSM states IDLE=2'b00, FILTRA=2'b01, PRESS=2'b10, BLOQ=2'b11, with an 8-bit cycle counter cnt.
REQ-011 IDLE: bt_s=1 and DEBOUNCE=1 -> PRESS; bt_s=1 and DEBOUNCE>1 -> FILTRA with cnt=1; else stay.
REQ-012 FILTRA: bt_s=0 -> IDLE with cnt=0; bt_s=1 and cnt+1==DEBOUNCE -> PRESS; otherwise cnt increments.
REQ-013 PRESS: bt_s=0 and BLOQUEIO=0 -> IDLE; bt_s=0 and BLOQUEIO>0 -> BLOQ with cnt=0; bt_s=1 -> stay (no further pulses).
REQ-014 BLOQ: bt_s ignored; cnt increments; cnt+1==BLOQUEIO -> IDLE with cnt=0.
REQ-015 bt SHALL be 1 exactly for the first cycle in PRESS, 0 otherwise; one pulse per accepted press regardless of hold length.
REQ-016 With bt_raw held stable high, bt SHALL rise after the (DEBOUNCE+2)th rising edge counted from the first edge sampling bt_raw=1.
REQ-017 contagem SHALL increment on each FSM entry into PRESS and saturate at 8'd255 (no wrap).
REQ-018 A press held through a release shorter than 1 cycle of bt_s SHALL NOT produce a second pulse; bt_s low for >=1 cycle in PRESS ends the press.
REQ-019 estado SHALL equal the registered FSM state code.

Reset
REQ-020 rst=1 SHALL immediately (asynchronously) force synchronizer flops=0, state=IDLE, cnt=0, bt=0, contagem=0, estado=2'b00.
REQ-021 rst asserted mid-operation (any state, including during the bt pulse) SHALL abort the press with no pulse completion; after rst falls the block SHALL start from IDLE on the next rising edge.

Structure
REQ-022 State encodings and default DEBOUNCE/BLOQUEIO values SHALL reside in the shared include semaforo_defs.vh, alongside the traffic-light timing constants.
REQ-023 The 2-flop synchronizer SHALL be a separate sub-module named sincronizador (ports clk, rst, d, q).
REQ-024 condicionador_botao output bt SHALL connect directly to semaforo.bt with no extra logic.

Verification
REQ-025 Reset: rst=1 for 1 cycle with bt_raw=1 -> bt=0, contagem=0, estado=00 during reset.
REQ-026 Clean press (DEBOUNCE=3): bt_raw=1 for 10 cycles -> bt=1 for exactly one cycle after 5th edge, contagem=1, estado=10 until release.
REQ-027 Glitch (DEBOUNCE=3): bt_raw=1 for 2 cycles then 0 -> bt never 1, estado returns 00, contagem=0.
REQ-028 Lockout (BLOQUEIO=4): release, re-press within 3 cycles -> no pulse; re-press after lockout and 5 stable cycles -> second pulse, contagem=2.
REQ-029 Saturation: 260 clean presses -> contagem=255 and stays 255.
REQ-030 Reset mid-press: rst raised during bt=1 cycle -> bt=0 before next edge, estado=00, contagem=0.
